// File: rtl/hid_serial_tx.sv
// hid_serial_tx: FIFO-buffered serializer for the 3-wire HID cable.
// Shifts words MSB first on clk/dat, then pulses str to latch them.
module hid_serial_tx #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned HALF_DIV   = 25,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned GAP        = 2,
  parameter bit          INVERT     = 1'b0
) (
  input  logic                          sys_clk,
  input  logic                          sys_rst_n,
  input  logic [DATA_W-1:0]             in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          busy,
  output logic                          hid_clk,
  output logic                          hid_dat,
  output logic                          hid_str
);

  localparam int unsigned AW      = $clog2(FIFO_DEPTH);
  localparam int unsigned LW      = AW + 1;
  localparam int unsigned GAP_CYC = GAP * HALF_DIV;
  localparam int unsigned CNT_MAX =
    (GAP_CYC > HALF_DIV) ? GAP_CYC : HALF_DIV;
  localparam int unsigned CW =
    (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int unsigned BW = $clog2(DATA_W + 1);

  localparam logic [CW-1:0] HALF_LD = CW'(HALF_DIV - 1);
  localparam logic [CW-1:0] GAP_LD  =
    CW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_BIT_LO,
    S_BIT_HI,
    S_STROBE,
    S_GAP
  } state_e;

  state_e              state_q;
  logic [CW-1:0]       cnt_q;
  logic [BW-1:0]       bitcnt_q;
  logic [DATA_W-1:0]   shreg_q;
  logic                clk_q, dat_q, str_q;

  logic [DATA_W-1:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0]       wr_q, rd_q;
  logic [LW-1:0]       lvl_q;
  logic                push, pop;

  assign in_ready   = (lvl_q != LW'(FIFO_DEPTH));
  assign push       = in_valid && in_ready;
  assign pop        = (state_q == S_IDLE) && (lvl_q != '0);
  assign fifo_level = lvl_q;
  assign busy       = (state_q != S_IDLE) || (lvl_q != '0);
  assign hid_clk    = clk_q;
  assign hid_dat    = dat_q;
  assign hid_str    = str_q;

  always_ff @(posedge sys_clk) begin
    if (push) mem_q[wr_q] <= in_data;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      lvl_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + 1'b1;
      if (pop)  rd_q <= rd_q + 1'b1;
      if (push && !pop)      lvl_q <= lvl_q + 1'b1;
      else if (pop && !push) lvl_q <= lvl_q - 1'b1;
    end
  end

  // Lines are a registered image of the current state, one cycle behind it.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      bitcnt_q <= '0;
      shreg_q  <= '0;
      clk_q    <= INVERT;
      dat_q    <= INVERT;
      str_q    <= INVERT;
    end else begin
      clk_q <= (state_q == S_BIT_HI) ^ INVERT;
      dat_q <= (((state_q == S_BIT_LO) || (state_q == S_BIT_HI))
                && shreg_q[DATA_W-1]) ^ INVERT;
      str_q <= (state_q == S_STROBE) ^ INVERT;
      unique case (state_q)
        S_IDLE: begin
          if (pop) begin
            shreg_q  <= mem_q[rd_q];
            bitcnt_q <= BW'(DATA_W);
            cnt_q    <= HALF_LD;
            state_q  <= S_BIT_LO;
          end
        end
        S_BIT_LO: begin
          if (cnt_q == '0) begin
            cnt_q   <= HALF_LD;
            state_q <= S_BIT_HI;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_BIT_HI: begin
          if (cnt_q == '0) begin
            shreg_q  <= {shreg_q[DATA_W-2:0], 1'b0};
            bitcnt_q <= bitcnt_q - 1'b1;
            cnt_q    <= HALF_LD;
            state_q  <= (bitcnt_q == BW'(1)) ? S_STROBE : S_BIT_LO;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_STROBE: begin
          if (cnt_q == '0) begin
            if (GAP == 0) begin
              state_q <= S_IDLE;
            end else begin
              cnt_q   <= GAP_LD;
              state_q <= S_GAP;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_GAP: begin
          if (cnt_q == '0) state_q <= S_IDLE;
          else             cnt_q   <= cnt_q - 1'b1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hid_serial_tx.sv
// tb_hid_serial_tx: directed vectors against a frame-position model,
// on three instances (normal, inverted lines, fastest timing).
module tb_hid_serial_tx;

  localparam int D = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        v0 = 1'b0, v2 = 1'b0;
  logic [15:0] d0 = '0, d2 = '0;

  logic [2:0] ordy, obusy, oclk, odat, ostr;
  logic [2:0] olvl [3];

  hid_serial_tx #(.DATA_W(16), .HALF_DIV(4), .FIFO_DEPTH(4),
                  .GAP(2), .INVERT(1'b0)) u0 (
    .sys_clk(clk), .sys_rst_n(rst_n),
    .in_data(d0), .in_valid(v0), .in_ready(ordy[0]),
    .fifo_level(olvl[0]), .busy(obusy[0]),
    .hid_clk(oclk[0]), .hid_dat(odat[0]), .hid_str(ostr[0]));

  hid_serial_tx #(.DATA_W(16), .HALF_DIV(4), .FIFO_DEPTH(4),
                  .GAP(2), .INVERT(1'b1)) u1 (
    .sys_clk(clk), .sys_rst_n(rst_n),
    .in_data(d0), .in_valid(v0), .in_ready(ordy[1]),
    .fifo_level(olvl[1]), .busy(obusy[1]),
    .hid_clk(oclk[1]), .hid_dat(odat[1]), .hid_str(ostr[1]));

  hid_serial_tx #(.DATA_W(16), .HALF_DIV(1), .FIFO_DEPTH(4),
                  .GAP(0), .INVERT(1'b0)) u2 (
    .sys_clk(clk), .sys_rst_n(rst_n),
    .in_data(d2), .in_valid(v2), .in_ready(ordy[2]),
    .fifo_level(olvl[2]), .busy(obusy[2]),
    .hid_clk(oclk[2]), .hid_dat(odat[2]), .hid_str(ostr[2]));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nvec = 0, nerr = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  // Reference: position inside the frame, counted from leaving idle.
  int PH [3] = '{4, 4, 1};
  int PG [3] = '{2, 2, 0};
  bit PI [3] = '{1'b0, 1'b1, 1'b0};

  int          fpos [3];
  int          mlev [3];
  logic [15:0] mbuf [3][4];
  logic [15:0] mw   [3];
  logic [2:0]  el   [3];

  function automatic logic [2:0] linef(input int pos,
                                       input logic [15:0] w,
                                       input int h);
    if (pos < 0) return 3'b000;
    if (pos < 2 * D * h)
      return {1'((pos / h) % 2), w[D - 1 - pos / (2 * h)], 1'b0};
    if (pos < (2 * D + 1) * h) return 3'b001;
    return 3'b000;
  endfunction

  logic        m_v;
  logic [15:0] m_w;
  int          m_fl;

  initial begin : model
    forever begin
      @(posedge clk or negedge rst_n);
      for (int d = 0; d < 3; d++) begin
        if (!rst_n) begin
          fpos[d] = -1;
          mlev[d] = 0;
          el[d]   = {3{PI[d]}};
        end else begin
          m_fl = (2 * D + 1 + PG[d]) * PH[d];
          m_v  = (d == 2) ? v2 : v0;
          m_w  = (d == 2) ? d2 : d0;
          el[d] = linef(fpos[d], mw[d], PH[d]) ^ {3{PI[d]}};
          if (fpos[d] < 0) begin
            if (mlev[d] > 0) begin
              mw[d] = mbuf[d][0];
              for (int k = 0; k < 3; k++) mbuf[d][k] = mbuf[d][k+1];
              mlev[d]--;
              fpos[d] = 0;
            end
          end else if (fpos[d] == m_fl - 1) begin
            fpos[d] = -1;
          end else begin
            fpos[d]++;
          end
          if (m_v && mlev[d] != 4) begin
            mbuf[d][mlev[d]] = m_w;
            mlev[d]++;
          end
        end
      end
    end
  end

  logic [7:0] ex, ac;
  logic [2:0] l0, l1;

  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      ex = {el[d], 1'(mlev[d] != 4),
            1'(fpos[d] >= 0 || mlev[d] != 0), 3'(mlev[d])};
      ac = {oclk[d], odat[d], ostr[d], ordy[d], obusy[d], olvl[d]};
      chk($sformatf("cycle_dut%0d", d), {24'b0, ac}, {24'b0, ex});
    end
    l0 = {oclk[0], odat[0], ostr[0]};
    l1 = {oclk[1], odat[1], ostr[1]};
    l0 = ~l0;
    chk("complement", {29'b0, l1}, {29'b0, l0});
  end

  // Line decoder: recovers words and edge timing from the pins.
  logic        pc [3], pd [3], ps [3];
  logic [15:0] cap [3];
  logic [15:0] dec [3][8];
  int          fr [3][8], nb [3][8];
  int nbit [3], nfr [3], nstr [3], strs [3], strl [3], strf [3];
  int lrise [3], gapm [3], fdr [3], bcnt [3], maxl [3];
  bit wd [3];
  logic lc, ld, ls;

  task automatic mon_clear();
    for (int d = 0; d < 3; d++) begin
      nbit[d] = 0; nfr[d] = 0; nstr[d] = 0; strs[d] = -1;
      strl[d] = 0; strf[d] = -1; lrise[d] = -1; gapm[d] = -1;
      fdr[d] = -1; bcnt[d] = 0; maxl[d] = 0; wd[d] = 1'b0;
      cap[d] = '0;
    end
  endtask

  initial begin : monitor
    for (int d = 0; d < 3; d++) begin
      pc[d] = 1'b0; pd[d] = 1'b0; ps[d] = 1'b0;
    end
    mon_clear();
    forever begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        lc = oclk[d] ^ PI[d];
        ld = odat[d] ^ PI[d];
        ls = ostr[d] ^ PI[d];
        if (lc && !pc[d]) begin
          if (nbit[d] == 0 && nfr[d] < 8) fr[d][nfr[d]] = cyc;
          cap[d] = {cap[d][14:0], ld};
          nbit[d]++;
          lrise[d] = cyc;
        end
        if (ld && !pd[d]) begin
          if (fdr[d] < 0) fdr[d] = cyc;
          if (wd[d]) begin
            if (gapm[d] < 0) gapm[d] = cyc - strf[d];
            wd[d] = 1'b0;
          end
        end
        if (ls && !ps[d]) begin
          nstr[d]++;
          strs[d] = cyc;
          strl[d] = 0;
        end
        if (ls) strl[d]++;
        if (!ls && ps[d]) begin
          strf[d] = cyc;
          wd[d] = 1'b1;
          if (nfr[d] < 8) begin
            dec[d][nfr[d]] = cap[d];
            nb[d][nfr[d]]  = nbit[d];
          end
          nfr[d]++;
          nbit[d] = 0;
        end
        if (obusy[d]) bcnt[d]++;
        if (int'(olvl[d]) > maxl[d]) maxl[d] = int'(olvl[d]);
        pc[d] = lc; pd[d] = ld; ps[d] = ls;
      end
    end
  end

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (obusy == 3'b000) break;
      @(posedge clk); #1;
    end
    chk("idle_timeout", {29'b0, obusy}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  int tp;

  initial begin : stim
    repeat (3) @(posedge clk);
    #1;
    chk("rst_lines", {29'b0, oclk[0], odat[0], ostr[0]}, 32'd0);
    chk("rst_lines_inv", {29'b0, oclk[1], odat[1], ostr[1]}, 32'd7);
    chk("rst_ready", {29'b0, ordy}, 32'd7);
    chk("rst_level", {29'b0, olvl[0]}, 32'd0);
    chk("rst_busy", {29'b0, obusy}, 32'd0);
    rst_n = 1'b1;
    step();

    // single word
    mon_clear();
    v0 = 1'b1; d0 = 16'hA5C3;
    step();
    tp = cyc; v0 = 1'b0;
    wait_idle(400);
    chk("t1_word", {16'b0, dec[0][0]}, 32'hA5C3);
    chk("t1_rises", nb[0][0], 32'd16);
    chk("t1_frames", nfr[0], 32'd1);
    chk("t1_latency", fdr[0] - tp, 32'd2);
    chk("t1_str_after_rise", strs[0] - lrise[0], 32'd4);
    chk("t1_str_len", strl[0], 32'd4);
    chk("t1_busy_cycles", bcnt[0], 32'd141);

    // overfill: six words offered, five fit
    mon_clear();
    v0 = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      d0 = 16'(i);
      if (i == 5) chk("t2_ready5", {31'b0, ordy[0]}, 32'd1);
      if (i == 6) chk("t2_ready6", {31'b0, ordy[0]}, 32'd0);
      step();
    end
    v0 = 1'b0;
    wait_idle(1500);
    chk("t2_frames", nfr[0], 32'd5);
    for (int i = 0; i < 5; i++)
      chk($sformatf("t2_word%0d", i), {16'b0, dec[0][i]}, 32'(i + 1));
    chk("t2_peak_level", maxl[0], 32'd4);

    // back-to-back gap
    mon_clear();
    v0 = 1'b1; d0 = 16'h1234;
    step();
    d0 = 16'h8001;
    step();
    v0 = 1'b0;
    wait_idle(600);
    chk("t3_gap", gapm[0], 32'd9);
    chk("t3_word1", {16'b0, dec[0][1]}, 32'h8001);

    // reset mid-frame
    mon_clear();
    v0 = 1'b1; d0 = 16'hFFFF;
    step();
    d0 = 16'h0F0F;
    step();
    d0 = 16'h3333;
    step();
    v0 = 1'b0;
    for (int i = 0; i < 300 && nbit[0] < 7; i++) step();
    chk("t4_in_bit_hi", {31'b0, oclk[0]}, 32'd1);
    chk("t4_queued", {29'b0, olvl[0]}, 32'd2);
    rst_n = 1'b0;
    #1;
    chk("t4_lines", {29'b0, oclk[0], odat[0], ostr[0]}, 32'd0);
    chk("t4_lines_inv", {29'b0, oclk[1], odat[1], ostr[1]}, 32'd7);
    chk("t4_level", {29'b0, olvl[0]}, 32'd0);
    chk("t4_busy", {29'b0, obusy}, 32'd0);
    chk("t4_ready", {31'b0, ordy[0]}, 32'd1);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (60) step();
    chk("t4_no_str", nstr[0], 32'd0);
    chk("t4_idle_after", {29'b0, oclk[0], odat[0], ostr[0]}, 32'd0);

    // inverted instance
    mon_clear();
    chk("t5_idle_inv", {29'b0, oclk[1], odat[1], ostr[1]}, 32'd7);
    v0 = 1'b1; d0 = 16'h0001;
    step();
    v0 = 1'b0;
    wait_idle(400);
    chk("t5_word_inv", {16'b0, dec[1][0]}, 32'h0001);
    chk("t5_word", {16'b0, dec[0][0]}, 32'h0001);

    // fastest timing
    mon_clear();
    v2 = 1'b1; d2 = 16'hFFFF;
    step();
    d2 = 16'h0000;
    step();
    v2 = 1'b0;
    wait_idle(200);
    chk("t6_frames", nfr[2], 32'd2);
    chk("t6_word0", {16'b0, dec[2][0]}, 32'hFFFF);
    chk("t6_word1", {16'b0, dec[2][1]}, 32'h0000);
    chk("t6_rises0", nb[2][0], 32'd16);
    chk("t6_rises1", nb[2][1], 32'd16);
    chk("t6_spacing", fr[2][1] - fr[2][0], 32'd34);
    chk("t6_str_len", strl[2], 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
